// File: rtl/hazard_fwd_unit_if.sv
// Bundle of pipeline-side signals for the hazard/forwarding unit.
// The pipeline drives through the master modport; the unit attaches to the slave modport.
interface hazard_fwd_unit_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [ADDR_W-1:0]         id_rd;
  logic                      id_regwrite;
  logic                      id_is_md;
  logic [NUM_SRC*ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0]         ex_rd;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic                      md_issue;
  logic [ADDR_W-1:0]         ex_mem_rd;
  logic                      ex_mem_regwrite;
  logic [ADDR_W-1:0]         mem_wb_rd;
  logic                      mem_wb_regwrite;
  logic                      perf_clr;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic                      flush_ex;
  logic                      md_done;
  logic                      md_busy;
  logic [ADDR_W-1:0]         md_rd_q;
  logic                      md_err;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_rs, id_rs_used, id_rd, id_regwrite, id_is_md,
    output ex_rs, ex_rd, ex_regwrite, ex_memread, md_issue,
    output ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite, perf_clr,
    input  fwd_sel, stall, flush_ex, md_done, md_busy, md_rd_q, md_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rs_used, id_rd, id_regwrite, id_is_md,
    input  ex_rs, ex_rd, ex_regwrite, ex_memread, md_issue,
    input  ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite, perf_clr,
    output fwd_sel, stall, flush_ex, md_done, md_busy, md_rd_q, md_err, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// EX-stage forwarding selects, ID-stage stall/bubble generation and a single-entry
// countdown scoreboard for the multi-cycle mul/div unit, plus a saturating stall counter.
module hazard_fwd_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            rstn,
  hazard_fwd_unit_if.slave bus
);
  localparam logic [3:0] MD_LOAD = 4'(MD_LAT);

  logic               md_busy_q, md_busy_d;
  logic [3:0]         md_cnt_q, md_cnt_d;
  logic [ADDR_W-1:0]  md_rd_q, md_rd_d;
  logic               md_err_q, md_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               md_done;
  logic               md_pend;
  logic               md_accept;
  logic               stall_c;
  logic [2*NUM_SRC-1:0] fwd_c;

  // x0 is hardwired zero, so it never participates in a dependency.
  function automatic logic match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] d);
    return (a == d) && (d != '0);
  endfunction

  // md_pend: result is still too far away for a consumer released now to catch the bypass.
  always_comb begin
    md_done   = md_busy_q && (md_cnt_q == 4'd1);
    md_pend   = md_busy_q && (md_cnt_q > 4'd2);
    md_accept = bus.md_issue && (!md_busy_q || md_done);
  end

  always_comb begin
    md_busy_d = md_busy_q;
    md_cnt_d  = md_cnt_q;
    md_rd_d   = md_rd_q;
    md_err_d  = md_err_q | (bus.md_issue && !md_accept);
    if (md_accept) begin
      md_busy_d = 1'b1;
      md_cnt_d  = MD_LOAD;
      md_rd_d   = bus.ex_rd;
    end else if (md_busy_q) begin
      md_cnt_d = md_cnt_q - 4'd1;
      if (md_cnt_q == 4'd1) md_busy_d = 1'b0;
    end
  end

  always_comb begin
    stall_c = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.id_rs_used[s]) begin
        if (bus.ex_memread && bus.ex_regwrite && match(bus.id_rs[s*ADDR_W +: ADDR_W], bus.ex_rd))
          stall_c = 1'b1;
        if (bus.md_issue && match(bus.id_rs[s*ADDR_W +: ADDR_W], bus.ex_rd))
          stall_c = 1'b1;
        if (md_pend && match(bus.id_rs[s*ADDR_W +: ADDR_W], md_rd_q))
          stall_c = 1'b1;
      end
    end
    if (md_pend && bus.id_regwrite && match(bus.id_rd, md_rd_q)) stall_c = 1'b1;
    if (bus.id_is_md && (md_pend || bus.md_issue)) stall_c = 1'b1;
    if (!rstn) stall_c = 1'b0;
  end

  // The mul/div bypass wins because it is the youngest value for that register.
  always_comb begin
    fwd_c = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (md_done && match(bus.ex_rs[s*ADDR_W +: ADDR_W], md_rd_q))
        fwd_c[2*s +: 2] = 2'b11;
      else if (bus.ex_mem_regwrite && match(bus.ex_rs[s*ADDR_W +: ADDR_W], bus.ex_mem_rd))
        fwd_c[2*s +: 2] = 2'b01;
      else if (bus.mem_wb_regwrite && match(bus.ex_rs[s*ADDR_W +: ADDR_W], bus.mem_wb_rd))
        fwd_c[2*s +: 2] = 2'b10;
    end
    if (!rstn) fwd_c = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.perf_clr)
      stall_cnt_d = '0;
    else if (stall_c && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      md_busy_q   <= 1'b0;
      md_cnt_q    <= 4'd0;
      md_rd_q     <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_busy_q   <= md_busy_d;
      md_cnt_q    <= md_cnt_d;
      md_rd_q     <= md_rd_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_sel   = fwd_c;
  assign bus.stall     = stall_c;
  assign bus.flush_ex  = stall_c;
  assign bus.md_done   = md_done;
  assign bus.md_busy   = md_busy_q;
  assign bus.md_rd_q   = md_rd_q;
  assign bus.md_err    = md_err_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_fwd_unit;
  localparam int ADDR_W = 5, NUM_SRC = 2, MD_LAT = 4, CNT_W = 4;

  localparam bit [6:0] C_FWD = 7'd1, C_STL = 7'd2, C_DONE = 7'd4, C_BUSY = 7'd8,
                       C_RD = 7'd16, C_ERR = 7'd32, C_CNT = 7'd64;

  typedef struct {
    string      name;
    bit [6:0]   care;
    logic [3:0] fwd;
    bit         stall;
    bit         done;
    bit         busy;
    logic [4:0] rd;
    bit         err;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

  hazard_fwd_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus.slave)
  );

  task automatic chk(input string n, input string f, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d expected=%0d", n, f, act, exp);
    end
  endtask

  task automatic push(input string n, input bit [6:0] care, input logic [3:0] fwd, input bit stall,
                      input bit done, input bit busy, input logic [4:0] rd, input bit err,
                      input logic [3:0] cnt);
    exp_t e;
    e.name = n; e.care = care; e.fwd = fwd; e.stall = stall; e.done = done;
    e.busy = busy; e.rd = rd; e.err = err; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs = '0; bus.id_rs_used = '0; bus.id_rd = '0; bus.id_regwrite = 0; bus.id_is_md = 0;
    bus.ex_rs = '0; bus.ex_rd = '0; bus.ex_regwrite = 0; bus.ex_memread = 0; bus.md_issue = 0;
    bus.ex_mem_rd = '0; bus.ex_mem_regwrite = 0; bus.mem_wb_rd = '0; bus.mem_wb_regwrite = 0;
    bus.perf_clr = 0;
  endtask

  task automatic load_use();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = 5'd7;
    bus.id_rs = {5'd7, 5'd0}; bus.id_rs_used = 2'b10;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.care[0]) chk(e.name, "fwd_sel", int'(bus.fwd_sel), int'(e.fwd));
      if (e.care[1]) begin
        chk(e.name, "stall", int'(bus.stall), int'(e.stall));
        chk(e.name, "flush_ex", int'(bus.flush_ex), int'(e.stall));
      end
      if (e.care[2]) chk(e.name, "md_done", int'(bus.md_done), int'(e.done));
      if (e.care[3]) chk(e.name, "md_busy", int'(bus.md_busy), int'(e.busy));
      if (e.care[4]) chk(e.name, "md_rd_q", int'(bus.md_rd_q), int'(e.rd));
      if (e.care[5]) chk(e.name, "md_err", int'(bus.md_err), int'(e.err));
      if (e.care[6]) chk(e.name, "stall_cnt", int'(bus.stall_cnt), int'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    step();
    push("rst", 7'h7F, 4'b0000, 0, 0, 0, 5'd0, 0, 4'd0);
    step();
    rstn = 1'b1;
    push("post_rst", 7'h7F, 4'b0000, 0, 0, 0, 5'd0, 0, 4'd0);

    // Forwarding priority and x0
    step(); idle();
    bus.ex_rs = {5'd0, 5'd5}; bus.ex_mem_rd = 5'd5; bus.mem_wb_rd = 5'd5;
    bus.ex_mem_regwrite = 1; bus.mem_wb_regwrite = 1;
    push("fwd_exmem", C_FWD | C_STL, 4'b0001, 0, 0, 0, 0, 0, 0);
    step(); bus.ex_mem_regwrite = 0;
    push("fwd_memwb", C_FWD, 4'b0010, 0, 0, 0, 0, 0, 0);
    step(); bus.ex_rs = {5'd0, 5'd0};
    push("fwd_rf", C_FWD, 4'b0000, 0, 0, 0, 0, 0, 0);
    step(); bus.ex_rs = {5'd3, 5'd0}; bus.ex_mem_rd = 5'd3; bus.mem_wb_rd = 5'd3;
    bus.ex_mem_regwrite = 1;
    push("fwd_rs2", C_FWD, 4'b0100, 0, 0, 0, 0, 0, 0);
    step(); bus.ex_rs = {5'd0, 5'd0}; bus.ex_mem_rd = 5'd0; bus.mem_wb_rd = 5'd0;
    push("fwd_x0", C_FWD, 4'b0000, 0, 0, 0, 0, 0, 0);

    // Load-use
    step(); idle(); load_use();
    push("lu_stall", C_STL, 0, 1, 0, 0, 0, 0, 0);
    step(); bus.id_rs_used = 2'b00;
    push("lu_unused", C_STL, 0, 0, 0, 0, 0, 0, 0);
    step(); idle();
    push("lu_cnt", C_STL | C_CNT, 0, 0, 0, 0, 0, 0, 4'd1);

    // Mul/div bypass
    step(); bus.md_issue = 1; bus.ex_rd = 5'd9; bus.id_rs = {5'd0, 5'd9}; bus.id_rs_used = 2'b01;
    push("md_T0", C_STL | C_BUSY | C_DONE, 0, 1, 0, 0, 0, 0, 0);
    step(); bus.md_issue = 0; bus.ex_rd = 5'd0;
    push("md_T1", C_STL | C_BUSY | C_RD | C_DONE, 0, 1, 0, 1, 5'd9, 0, 0);
    step(); push("md_T2", C_STL | C_DONE, 0, 1, 0, 1, 0, 0, 0);
    step(); push("md_T3", C_STL | C_DONE | C_BUSY, 0, 0, 0, 1, 0, 0, 0);
    step(); idle(); bus.ex_rs = {5'd0, 5'd9}; bus.ex_mem_rd = 5'd9; bus.ex_mem_regwrite = 1;
    push("md_T4", C_DONE | C_FWD | C_BUSY | C_STL, 4'b0011, 0, 1, 1, 0, 0, 0);
    step(); push("md_T5", C_DONE | C_BUSY | C_FWD | C_CNT, 4'b0001, 0, 0, 0, 0, 0, 4'd4);

    // Back-to-back issue and ignored issue
    step(); idle(); bus.md_issue = 1; bus.ex_rd = 5'd10;
    push("b2b_A0", C_BUSY, 0, 0, 0, 0, 0, 0, 0);
    step(); bus.md_issue = 0;
    push("b2b_A1", C_BUSY | C_RD | C_DONE, 0, 0, 0, 1, 5'd10, 0, 0);
    step(); push("b2b_A2", C_DONE, 0, 0, 0, 0, 0, 0, 0);
    step(); push("b2b_A3", C_DONE, 0, 0, 0, 0, 0, 0, 0);
    step(); bus.md_issue = 1; bus.ex_rd = 5'd11;
    push("b2b_A4", C_DONE | C_ERR | C_BUSY | C_RD, 0, 0, 1, 1, 5'd10, 0, 0);
    step(); bus.md_issue = 0;
    push("b2b_A5", C_BUSY | C_RD | C_DONE | C_ERR, 0, 0, 0, 1, 5'd11, 0, 0);
    step(); bus.md_issue = 1; bus.ex_rd = 5'd12;
    push("b2b_A6", C_DONE | C_ERR | C_BUSY, 0, 0, 0, 1, 0, 0, 0);
    step(); bus.md_issue = 0;
    push("b2b_A7", C_ERR | C_RD | C_BUSY | C_DONE, 0, 0, 0, 1, 5'd11, 1, 0);
    step(); push("b2b_A8", C_DONE, 0, 0, 1, 0, 0, 0, 0);
    step(); push("b2b_A9", C_BUSY | C_ERR | C_DONE | C_CNT, 0, 0, 0, 0, 0, 1, 4'd4);

    // Reset in the middle of an op
    step(); idle(); bus.md_issue = 1; bus.ex_rd = 5'd13;
    step(); bus.md_issue = 0;
    step();
    step(); rstn = 1'b0;
    push("rmid_B3", C_BUSY | C_DONE | C_ERR | C_CNT | C_STL, 0, 0, 0, 0, 0, 0, 4'd0);
    step(); push("rmid_B4", C_BUSY | C_DONE, 0, 0, 0, 0, 0, 0, 0);
    step(); rstn = 1'b1;
    push("rmid_B5", C_BUSY | C_DONE | C_ERR | C_CNT, 0, 0, 0, 0, 0, 0, 4'd0);
    step(); push("rmid_B6", C_BUSY | C_DONE, 0, 0, 0, 0, 0, 0, 0);
    step(); push("rmid_B7", C_BUSY | C_DONE, 0, 0, 0, 0, 0, 0, 0);

    // WAW, structural, rd=0 occupancy
    step(); idle(); bus.md_issue = 1; bus.ex_rd = 5'd6;
    push("waw_C0", C_STL, 0, 0, 0, 0, 0, 0, 0);
    step(); bus.md_issue = 0; bus.ex_rd = 5'd0; bus.id_regwrite = 1; bus.id_rd = 5'd6;
    push("waw_C1", C_STL, 0, 1, 0, 0, 0, 0, 0);
    step(); bus.id_regwrite = 0; bus.id_rd = 5'd0; bus.id_is_md = 1;
    push("struct_C2", C_STL, 0, 1, 0, 0, 0, 0, 0);
    step(); push("struct_C3", C_STL, 0, 0, 0, 0, 0, 0, 0);
    step(); bus.md_issue = 1; bus.ex_rd = 5'd0;
    push("struct_C4", C_STL | C_DONE, 0, 1, 1, 0, 0, 0, 0);
    step(); bus.md_issue = 0; bus.id_is_md = 0; bus.id_rs = '0; bus.id_rs_used = 2'b01;
    push("x0_C5", C_STL | C_BUSY | C_RD, 0, 0, 0, 1, 5'd0, 0, 0);
    step(); idle(); push("x0_C6", C_BUSY, 0, 0, 0, 1, 0, 0, 0);
    step(); step();
    step(); push("x0_C9", C_BUSY | C_CNT, 0, 0, 0, 0, 0, 0, 4'd3);

    // Saturating counter and clear priority
    step(); idle(); bus.perf_clr = 1;
    push("cnt_clr0", C_CNT, 0, 0, 0, 0, 0, 0, 4'd3);
    for (int i = 0; i < 20; i++) begin
      step(); bus.perf_clr = 0; load_use();
      push($sformatf("cnt_%0d", i), C_STL | C_CNT, 0, 1, 0, 0, 0, 0, 4'((i > 15) ? 15 : i));
    end
    step(); bus.perf_clr = 1;
    push("cnt_sat", C_STL | C_CNT, 0, 1, 0, 0, 0, 0, 4'd15);
    step(); idle();
    push("cnt_clr1", C_STL | C_CNT, 0, 0, 0, 0, 0, 0, 4'd0);
    step(); push("cnt_clr2", C_CNT, 0, 0, 0, 0, 0, 0, 4'd0);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
